// File: rtl/struct.sv
// Shared definitions for the reservation-station forwarding scheduler.
//   slot_state_e : per-slot operand state machine encoding
//   FWD_NONE     : select code meaning "no forwarding source"
//   NUM_FU       : number of functional units broadcasting tags
package rs_fwd_sched_pkg;

    localparam int unsigned NUM_FU   = 10;
    localparam logic [3:0]  FWD_NONE = 4'hf;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StHit,
        StHit2,
        StReady,
        StMiss
    } slot_state_e;

endpackage

// File: rtl/rs_fwd_slot.sv
// Single operand slot: tracks one awaited producer tag, catches its broadcast on any of the
// NUM_FU writeback buses and steers the forwarding muxes for the two cycles the value is live.
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   alloc_i                 allocation addressed to this slot
//   alloc_tag_i/alloc_rdy_i awaited tag / operand already in register file
//   wb_vld_i, wb_tag_i      tag broadcasts, FUn at [n*TAG_WIDTH +: TAG_WIDTH]
//   stall_i                 forwarding datapath holds this cycle
//   issue_i, flush_i        free this slot / clear everything
//   fwd_o, fwdu_o           live-FU and registered-FU select codes
//   rdy_o, replay_o, err_o  captured / window missed / allocation hit a busy slot
module rs_fwd_slot
    import rs_fwd_sched_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = 9
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        alloc_i,
    input  logic [TAG_WIDTH-1:0]        alloc_tag_i,
    input  logic                        alloc_rdy_i,
    input  logic [NUM_FU-1:0]           wb_vld_i,
    input  logic [NUM_FU*TAG_WIDTH-1:0] wb_tag_i,
    input  logic                        stall_i,
    input  logic                        issue_i,
    input  logic                        flush_i,
    output logic [3:0]                  fwd_o,
    output logic [3:0]                  fwdu_o,
    output logic                        rdy_o,
    output logic                        replay_o,
    output logic                        err_o
);

    slot_state_e          state_q, state_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [3:0]           fu_q, fu_d;
    logic                 ok_q, ok_d;    // stall was low during the HIT cycle
    logic                 err_q, err_d;

    logic                 eff_idle;
    logic                 alloc_ok;
    logic [TAG_WIDTH-1:0] cmp_tag;
    logic                 hit;
    logic [3:0]           hit_fu;

    always_comb begin
        // An issue to this slot in the same cycle frees it before the allocation is considered.
        eff_idle = (state_q == StIdle) || issue_i;
        alloc_ok = alloc_i && eff_idle;
        // A fresh allocation compares its own tag for the same-cycle bypass.
        cmp_tag  = alloc_ok ? alloc_tag_i : tag_q;
        hit      = 1'b0;
        hit_fu   = FWD_NONE;
        // Scan downwards so the lowest matching FU index is the one left standing.
        for (int n = int'(NUM_FU) - 1; n >= 0; n--) begin
            if (wb_vld_i[n] && (wb_tag_i[n*TAG_WIDTH +: TAG_WIDTH] == cmp_tag)) begin
                hit    = 1'b1;
                hit_fu = 4'(n);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        fu_d    = fu_q;
        ok_d    = ok_q;
        err_d   = 1'b0;

        case (state_q)
            StWait: begin
                if (hit) begin
                    state_d = StHit;
                    fu_d    = hit_fu;
                end
            end
            StHit: begin
                state_d = StHit2;
                ok_d    = !stall_i;
            end
            StHit2:  state_d = (ok_q || !stall_i) ? StReady : StMiss;
            default: ;
        endcase

        if (issue_i) begin
            state_d = StIdle;
        end

        if (alloc_i) begin
            if (eff_idle) begin
                tag_d = alloc_tag_i;
                if (alloc_rdy_i) begin
                    state_d = StReady;
                end else if (hit) begin
                    state_d = StHit;
                    fu_d    = hit_fu;
                end else begin
                    state_d = StWait;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        if (flush_i) begin
            state_d = StIdle;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            tag_q   <= '0;
            fu_q    <= FWD_NONE;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            fu_q    <= fu_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode flops only, so reset clears them without waiting for a clock.
    assign fwd_o    = (state_q == StHit)  ? fu_q : FWD_NONE;
    assign fwdu_o   = (state_q == StHit2) ? fu_q : FWD_NONE;
    assign rdy_o    = (state_q == StReady);
    assign replay_o = (state_q == StMiss);
    assign err_o    = err_q;

endmodule

// File: rtl/rs_fwd_sched.sv
// Forwarding scheduler for NSLOT reservation-station operands. Each slot watches the ten FU
// tag broadcasts and tells the datapath which FU to forward from (live stage, then registered
// stage), or asks for a register-file reread when a stall made the window slip past.
//   clk, rst                    clock, asynchronous active-low reset
//   alloc_en/slot/tag/rdy       slot allocation
//   wb_vld, wb_tag              FU tag broadcasts
//   stall                       datapath hold
//   issue_en/issue_slot, flush  slot release / global clear
//   fuFwd, fuuFwd               per-slot 4-bit select codes, slot i at [4*i +: 4]
//   rdy, replay_req, alloc_err  per-slot status and busy-slot allocation pulse
module rs_fwd_sched
    import rs_fwd_sched_pkg::*;
#(
    parameter int unsigned NSLOT     = 4,
    parameter int unsigned TAG_WIDTH = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_en,
    input  logic [$clog2(NSLOT)-1:0]    alloc_slot,
    input  logic [TAG_WIDTH-1:0]        alloc_tag,
    input  logic                        alloc_rdy,
    input  logic [NUM_FU-1:0]           wb_vld,
    input  logic [NUM_FU*TAG_WIDTH-1:0] wb_tag,
    input  logic                        stall,
    input  logic                        issue_en,
    input  logic [$clog2(NSLOT)-1:0]    issue_slot,
    input  logic                        flush,
    output logic [4*NSLOT-1:0]          fuFwd,
    output logic [4*NSLOT-1:0]          fuuFwd,
    output logic [NSLOT-1:0]            rdy,
    output logic [NSLOT-1:0]            replay_req,
    output logic                        alloc_err
);

    localparam int unsigned SlotW = $clog2(NSLOT);

    logic [NSLOT-1:0] err_vec;

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        rs_fwd_slot #(
            .TAG_WIDTH(TAG_WIDTH)
        ) u_slot (
            .clk_i      (clk),
            .rst_ni     (rst),
            .alloc_i    (alloc_en && (alloc_slot == SlotW'(i))),
            .alloc_tag_i(alloc_tag),
            .alloc_rdy_i(alloc_rdy),
            .wb_vld_i   (wb_vld),
            .wb_tag_i   (wb_tag),
            .stall_i    (stall),
            .issue_i    (issue_en && (issue_slot == SlotW'(i))),
            .flush_i    (flush),
            .fwd_o      (fuFwd[4*i +: 4]),
            .fwdu_o     (fuuFwd[4*i +: 4]),
            .rdy_o      (rdy[i]),
            .replay_o   (replay_req[i]),
            .err_o      (err_vec[i])
        );
    end

    // Only one slot can be addressed per cycle, so at most one bit is ever set.
    assign alloc_err = |err_vec;

endmodule

// File: tb/tb_rs_fwd_sched.sv
module tb_rs_fwd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_en;
    logic [1:0]  alloc_slot;
    logic [8:0]  alloc_tag;
    logic        alloc_rdy;
    logic [9:0]  wb_vld;
    logic [89:0] wb_tag;
    logic        stall;
    logic        issue_en;
    logic [1:0]  issue_slot;
    logic        flush;
    logic [15:0] fuFwd;
    logic [15:0] fuuFwd;
    logic [3:0]  rdy;
    logic [3:0]  replay_req;
    logic        alloc_err;

    rs_fwd_sched #(
        .NSLOT    (4),
        .TAG_WIDTH(9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (alloc_en),
        .alloc_slot(alloc_slot),
        .alloc_tag (alloc_tag),
        .alloc_rdy (alloc_rdy),
        .wb_vld    (wb_vld),
        .wb_tag    (wb_tag),
        .stall     (stall),
        .issue_en  (issue_en),
        .issue_slot(issue_slot),
        .flush     (flush),
        .fuFwd     (fuFwd),
        .fuuFwd    (fuuFwd),
        .rdy       (rdy),
        .replay_req(replay_req),
        .alloc_err (alloc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ae;
        logic [1:0]  as;
        logic [8:0]  at;
        logic        ar;
        logic [9:0]  wv;
        logic [89:0] wt;
        logic        st;
        logic        ie;
        logic [1:0]  is;
        logic        fl;
        logic [15:0] ef;
        logic [15:0] eu;
        logic [3:0]  er;
        logic [3:0]  ep;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [15:0] ef;
        logic [15:0] eu;
        logic [3:0]  er;
        logic [3:0]  ep;
        logic        ee;
    } exp_t;

    localparam logic [15:0] NN = 16'hffff;
    localparam logic [89:0] W0 = '0;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic logic [89:0] wt(input int fu, input logic [8:0] tag);
        logic [89:0] r;
        r = '0;
        r[fu*9 +: 9] = tag;
        return r;
    endfunction

    function automatic vec_t mkv(
        input logic ae, input logic [1:0] as, input logic [8:0] at, input logic ar,
        input logic [9:0] wv, input logic [89:0] w, input logic st, input logic ie,
        input logic [1:0] is, input logic fl, input logic [15:0] ef, input logic [15:0] eu,
        input logic [3:0] er, input logic [3:0] ep, input logic ee);
        vec_t v;
        v.ae = ae; v.as = as; v.at = at; v.ar = ar; v.wv = wv; v.wt = w; v.st = st;
        v.ie = ie; v.is = is; v.fl = fl; v.ef = ef; v.eu = eu; v.er = er; v.ep = ep;
        v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
        end
    endtask

    task automatic chk_all(input int step, input exp_t e);
        chk("fuFwd", step, 32'(fuFwd), 32'(e.ef));
        chk("fuuFwd", step, 32'(fuuFwd), 32'(e.eu));
        chk("rdy", step, 32'(rdy), 32'(e.er));
        chk("replay_req", step, 32'(replay_req), 32'(e.ep));
        chk("alloc_err", step, 32'(alloc_err), 32'(e.ee));
    endtask

    task automatic drive(input vec_t v);
        alloc_en   = v.ae;
        alloc_slot = v.as;
        alloc_tag  = v.at;
        alloc_rdy  = v.ar;
        wb_vld     = v.wv;
        wb_tag     = v.wt;
        stall      = v.st;
        issue_en   = v.ie;
        issue_slot = v.is;
        flush      = v.fl;
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.ef = NN; e.eu = NN; e.er = 4'h0; e.ep = 4'h0; e.ee = 1'b0;
        return e;
    endfunction

    vec_t nop;
    exp_t e_cur;

    initial begin
        nop = mkv(1'b0, 2'd0, 9'h0, 1'b0, 10'h0, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                  NN, NN, 4'h0, 4'h0, 1'b0);

        // single FU4 hit, no stall: live, registered, ready, then issue
        vecs.push_back(mkv(1'b1, 2'd0, 9'h023, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h010, wt(4, 9'h023), 1'b0, 1'b0, 2'd0,
                           1'b0, 16'hfff4, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, 16'hfff4, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h1, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b1, 2'd0, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        // same, stalled across HIT and HIT2: miss, held, cleared by issue
        vecs.push_back(mkv(1'b1, 2'd0, 9'h023, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h010, wt(4, 9'h023), 1'b0, 1'b0, 2'd0,
                           1'b0, 16'hfff4, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b1, 1'b0, 2'd0, 1'b0,
                           NN, 16'hfff4, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b1, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h0, 4'h1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h0, 4'h1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b1, 2'd0, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        // FU2 and FU7 both match: lowest wins
        vecs.push_back(mkv(1'b1, 2'd2, 9'h055, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h084, wt(2, 9'h055) | wt(7, 9'h055),
                           1'b0, 1'b0, 2'd0, 1'b0, 16'hf2ff, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, 16'hf2ff, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h4, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b1, 2'd2, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        // FU9 match (FU8 valid with a neighbouring tag must not match)
        vecs.push_back(mkv(1'b1, 2'd3, 9'h1ff, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h300, wt(9, 9'h1ff) | wt(8, 9'h1fe),
                           1'b0, 1'b0, 2'd0, 1'b0, 16'h9fff, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, 16'h9fff, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h8, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b1, 2'd3, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        // same-cycle bypass on FU0
        vecs.push_back(mkv(1'b1, 2'd1, 9'h010, 1'b0, 10'h001, wt(0, 9'h010), 1'b0, 1'b0, 2'd0,
                           1'b0, 16'hff0f, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, 16'hff0f, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h2, 4'h0, 1'b0));
        // busy allocation: error pulse, slot unchanged
        vecs.push_back(mkv(1'b1, 2'd1, 9'h044, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h2, 4'h0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h2, 4'h0, 1'b0));
        // issue + alloc same slot, then hit on FU6; slot0 allocated already-ready
        vecs.push_back(mkv(1'b1, 2'd1, 9'h044, 1'b0, 10'h000, W0, 1'b0, 1'b1, 2'd1, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 9'h000, 1'b1, 10'h040, wt(6, 9'h044), 1'b0, 1'b0, 2'd0,
                           1'b0, 16'hff6f, NN, 4'h1, 4'h0, 1'b0));
        // flush during HIT overrides a concurrent allocation
        vecs.push_back(mkv(1'b1, 2'd2, 9'h000, 1'b1, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b1,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        // invalid broadcast with matching tag is ignored
        vecs.push_back(mkv(1'b1, 2'd3, 9'h012, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h002, wt(1, 9'h013) | wt(5, 9'h012),
                           1'b0, 1'b0, 2'd0, 1'b0, NN, NN, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h000, W0, 1'b0, 1'b1, 2'd3, 1'b0,
                           NN, NN, 4'h0, 4'h0, 1'b0));

        // reset state
        rst = 1'b0;
        drive(nop);
        @(negedge clk);
        @(negedge clk);
        chk_all(-1, idle_exp());
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            e_cur.ef = vecs[i].ef;
            e_cur.eu = vecs[i].eu;
            e_cur.er = vecs[i].er;
            e_cur.ep = vecs[i].ep;
            e_cur.ee = vecs[i].ee;
            sb.push_back(e_cur);
            @(negedge clk);
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL scoreboard step %0d: got empty queue expected entry", i);
            end else begin
                chk_all(i, sb.pop_front());
            end
        end

        // asynchronous reset while slot0 sits in HIT2
        drive(mkv(1'b1, 2'd0, 9'h023, 1'b0, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                  NN, NN, 4'h0, 4'h0, 1'b0));
        @(negedge clk);
        drive(mkv(1'b0, 2'd0, 9'h000, 1'b0, 10'h010, wt(4, 9'h023), 1'b0, 1'b0, 2'd0, 1'b0,
                  NN, NN, 4'h0, 4'h0, 1'b0));
        @(negedge clk);
        chk("rst_hit_fuFwd", 100, 32'(fuFwd), 32'(16'hfff4));
        drive(nop);
        @(negedge clk);
        chk("rst_hit2_fuuFwd", 101, 32'(fuuFwd), 32'(16'hfff4));
        #2 rst = 1'b0;
        #1 chk_all(102, idle_exp());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all(103, idle_exp());
        drive(mkv(1'b1, 2'd0, 9'h000, 1'b1, 10'h000, W0, 1'b0, 1'b0, 2'd0, 1'b0,
                  NN, NN, 4'h0, 4'h0, 1'b0));
        @(negedge clk);
        chk("post_rst_rdy", 104, 32'(rdy), 32'(4'h1));
        chk("post_rst_err", 104, 32'(alloc_err), 32'(1'b0));
        drive(nop);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
